// File: rtl/ps2_dev_tx_multi.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_dev_tx_multi
//  Purpose  : Multi-channel PS/2 device-side transmitter. Each channel queues
//             bytes in its own FIFO and sends them as 11-bit PS/2 frames
//             (start, 8 data LSB first, odd parity, stop). A programmable
//             idle gap separates frames on one channel. A host inhibit aborts
//             the frame in flight, and the same byte is resent later.
//  Ports    : clk_sys, reset_n       - system clock, async active-low reset
//             wr, wr_ch, wr_data     - byte write strobe / channel / data
//             inhibit[CHANNELS]      - host holding the clock low, per channel
//             ovf_clr[CHANNELS]      - clear sticky overflow, per channel
//             ps2_clk, ps2_data      - PS/2 lines, per channel (idle high)
//             busy                   - frame in progress, per channel
//             overflow               - sticky "write dropped on full FIFO"
//             fifo_level             - entry count, FIFO_BITS+1 bits/channel
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_dev_tx_multi #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 20,
  parameter int GAP       = 2
) (
  input  logic                              clk_sys,
  input  logic                              reset_n,
  input  logic                              wr,
  input  logic [2:0]                        wr_ch,
  input  logic [7:0]                        wr_data,
  input  logic [CHANNELS-1:0]               inhibit,
  input  logic [CHANNELS-1:0]               ovf_clr,
  output logic [CHANNELS-1:0]               ps2_clk,
  output logic [CHANNELS-1:0]               ps2_data,
  output logic [CHANNELS-1:0]               busy,
  output logic [CHANNELS-1:0]               overflow,
  output logic [CHANNELS*(FIFO_BITS+1)-1:0] fifo_level
);

  localparam int C_DEPTH = 1 << FIFO_BITS;
  localparam int C_LVL_W = FIFO_BITS + 1;
  localparam int C_CNT_W = (PS2DIV < 1) ? 1 : $clog2(PS2DIV + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_D0   = 4'd1,
    S_D1   = 4'd2,
    S_D2   = 4'd3,
    S_D3   = 4'd4,
    S_D4   = 4'd5,
    S_D5   = 4'd6,
    S_D6   = 4'd7,
    S_D7   = 4'd8,
    S_PAR  = 4'd9,
    S_STOP = 4'd10,
    S_END  = 4'd11
  } state_t;

  // --------------------------------------------------------------------------
  // Shared PS/2 clock divider. The tick is the cycle on which the divided
  // clock rises, so every channel changes its data line together with the
  // rising clock and the host samples stable data on the falling edge.
  // --------------------------------------------------------------------------
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_clk_ps2;
  logic               w_div_wrap;
  logic               w_tick;

  assign w_div_wrap = (r_cnt == C_CNT_W'(PS2DIV));
  assign w_tick     = w_div_wrap & ~r_clk_ps2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_clk_ps2 <= 1'b0;
    end else if (w_div_wrap) begin
      r_cnt     <= '0;
      r_clk_ps2 <= ~r_clk_ps2;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel FIFO + frame FSM
  // --------------------------------------------------------------------------
  genvar n;
  generate
    for (n = 0; n < CHANNELS; n++) begin : g_ch
      logic [7:0]           r_mem [C_DEPTH];
      logic [FIFO_BITS-1:0] r_wptr;
      logic [FIFO_BITS-1:0] r_rptr;
      logic [C_LVL_W-1:0]   r_level;
      logic                 r_ovf;
      state_t               r_state;
      state_t               w_state_nx;
      logic [7:0]           r_shift;
      logic [7:0]           w_shift_nx;
      logic                 r_par;
      logic                 w_par_nx;
      logic                 r_data;
      logic                 w_data_nx;
      logic [3:0]           r_gap;
      logic [3:0]           w_gap_nx;
      logic                 w_pop;
      logic                 w_sel;
      logic                 w_full;
      logic                 w_wr_ok;
      logic                 w_ovf_set;

      // A pop frees a slot in the same cycle, so a write to a full FIFO that
      // coincides with the stop-bit pop is accepted rather than dropped. The
      // overwritten slot was already copied into the shift register at start.
      assign w_sel     = wr && (wr_ch == 3'(n));
      assign w_full    = (r_level == C_LVL_W'(C_DEPTH));
      assign w_wr_ok   = w_sel && (!w_full || w_pop);
      assign w_ovf_set = w_sel && w_full && !w_pop;

      always_ff @(posedge clk_sys) begin
        if (w_wr_ok) begin
          r_mem[r_wptr] <= wr_data;
        end
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_level <= '0;
          r_ovf   <= 1'b0;
        end else begin
          if (w_wr_ok) begin
            r_wptr <= r_wptr + 1'b1;
          end
          if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
          end
          case ({w_wr_ok, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
          endcase
          // Set has priority over clear.
          if (w_ovf_set) begin
            r_ovf <= 1'b1;
          end else if (ovf_clr[n]) begin
            r_ovf <= 1'b0;
          end
        end
      end

      // Frame state register
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= S_IDLE;
          r_shift <= '0;
          r_par   <= 1'b0;
          r_data  <= 1'b1;
          r_gap   <= '0;
        end else begin
          r_state <= w_state_nx;
          r_shift <= w_shift_nx;
          r_par   <= w_par_nx;
          r_data  <= w_data_nx;
          r_gap   <= w_gap_nx;
        end
      end

      // Frame next-state logic; everything advances on the divider tick only.
      always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_data_nx  = r_data;
        w_gap_nx   = r_gap;
        w_pop      = 1'b0;
        if (w_tick) begin
          case (r_state)
            S_IDLE: begin
              if ((r_level != '0) && (r_gap == 4'd0) && !inhibit[n]) begin
                w_shift_nx = r_mem[r_rptr];
                w_par_nx   = 1'b1;
                w_data_nx  = 1'b0;
                w_state_nx = S_D0;
              end else if (r_gap != 4'd0) begin
                w_gap_nx = r_gap - 4'd1;
              end
            end
            S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7: begin
              if (inhibit[n]) begin
                // Abort without popping: the byte stays at the FIFO head.
                w_state_nx = S_IDLE;
                w_data_nx  = 1'b1;
                w_gap_nx   = 4'(GAP);
              end else begin
                w_data_nx  = r_shift[0];
                w_shift_nx = {1'b0, r_shift[7:1]};
                w_par_nx   = r_par ^ r_shift[0];
                w_state_nx = state_t'(r_state + 4'd1);
              end
            end
            S_PAR: begin
              if (inhibit[n]) begin
                w_state_nx = S_IDLE;
                w_data_nx  = 1'b1;
                w_gap_nx   = 4'(GAP);
              end else begin
                w_data_nx  = r_par;
                w_state_nx = S_STOP;
              end
            end
            S_STOP: begin
              w_data_nx  = 1'b1;
              w_pop      = 1'b1;
              w_state_nx = S_END;
            end
            S_END: begin
              w_state_nx = S_IDLE;
              w_gap_nx   = 4'(GAP);
            end
            default: begin
              w_state_nx = S_IDLE;
              w_data_nx  = 1'b1;
            end
          endcase
        end
      end

      assign ps2_clk[n]                         = r_clk_ps2 | (r_state == S_IDLE);
      assign ps2_data[n]                        = r_data;
      assign busy[n]                            = (r_state != S_IDLE);
      assign overflow[n]                        = r_ovf;
      assign fifo_level[n*C_LVL_W +: C_LVL_W]   = r_level;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/ps2_dev_tx_multi.md
Name: ps2_dev_tx_multi

Overview:
Parametrised multi-channel PS/2 device-side transmitter. It is the successor to the fixed keyboard/mouse transmitters inside the IO controller. Each channel has a FIFO of configurable depth, a true full/empty indication with a sticky overflow flag, a configurable inter-byte gap, and host-inhibit abort with retransmit. It sits between the SPI command decoder (producer of scan/mouse bytes) and the core's PS/2 clk/data inputs, all in the clk_sys domain.

Parameters:
CHANNELS, 2, number of independent PS/2 channels (ch0 keyboard, ch1 mouse by convention), 1..8
FIFO_BITS, 3, log2 of FIFO depth per channel; depth = 2^FIFO_BITS entries, all usable
PS2DIV, 20, PS/2 half-period = PS2DIV+1 clk_sys cycles
GAP, 2, idle PS/2 clock periods enforced between consecutive frames on one channel, 0..15

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
wr  in  1  write strobe, one byte per cycle
wr_ch  in  3  target channel for wr; values >= CHANNELS are ignored (no write, no flag)
wr_data  in  8  byte to queue
inhibit  in  CHANNELS  host inhibit per channel (host holding clock low), synchronous to clk_sys
ovf_clr  in  CHANNELS  clear sticky overflow per channel
ps2_clk  out  CHANNELS  PS/2 clock per channel
ps2_data  out  CHANNELS  PS/2 data per channel
busy  out  CHANNELS  frame in progress (state != IDLE)
overflow  out  CHANNELS  sticky: a write was dropped because the FIFO was full
fifo_level  out  CHANNELS*(FIFO_BITS+1)  entry count per channel; ch n at [n*(FIFO_BITS+1) +: FIFO_BITS+1]

Behaviour:
- Reset (async, reset_n low): divider count 0, clk_ps2 0, all FIFOs empty (wptr=rptr=0, level 0), state IDLE, gap counter 0, ps2_clk all 1, ps2_data all 1, busy 0, overflow 0. On release, first tick no earlier than PS2DIV+1 cycles later.
- Divider: shared across channels. cnt increments each cycle; at cnt==PS2DIV it toggles clk_ps2 and resets to 0. tick = one-cycle pulse on the cycle clk_ps2 goes 0->1. All channel FSMs advance only on tick.
- ps2_clk[n] = clk_ps2 OR (state==IDLE). Line idles high.
- FIFO write: with wr and wr_ch==n, the byte is stored at wptr and level increments, unless level==2^FIFO_BITS. In that case the byte is dropped and overflow[n] is set. Write and pop in the same cycle: both occur, level unchanged; write into a full FIFO with a simultaneous pop is accepted.
- overflow[n]: ovf_clr[n] clears it; if set and clear occur in the same cycle, set wins.
- FSM per channel, states 0..11, evaluated on tick:
  - IDLE(0): if level!=0, gap counter==0 and inhibit low: shift reg <= fifo[rptr], parity <= 1, data <= 0 (start bit), state <= 1. Otherwise, if gap counter!=0, it decrements.
  - 1..8: data <= shift[0], shift right, parity toggles on each 1 sent (odd parity).
  - 9: data <= parity.
  - 10: data <= 1 (stop); pop FIFO (rptr+1, level-1) on this tick.
  - 11: state <= IDLE, gap counter <= GAP.
- Inhibit abort: if inhibit[n] is high at a tick while state is 1..9: state <= IDLE, data <= 1, no pop, gap counter <= GAP. The same byte is retransmitted in full later. Inhibit in states 10/11 is ignored (frame completes). In IDLE, inhibit holds off the start.
- Pointers wrap modulo 2^FIFO_BITS; level is FIFO_BITS+1 bits wide, so full and empty are distinguishable.
- Frame length: 11 data-line bits, 12 ticks from start to IDLE; with GAP=g the next start is at tick 12+g after the previous start.
- busy[n] = (state != IDLE).

Test Plan:
- PS2DIV=1, GAP=0, write 0x1C to ch0 -> ps2_data[0] sampled at ps2_clk falling edges: 0,0,0,1,1,1,0,0,0,0(parity: three ones -> 0),1; ps2_clk[1] stays high; fifo_level ch0 returns to 0 on the stop tick.
- FIFO_BITS=3, 9 back-to-back writes to ch1 with the transmitter stalled by inhibit[1]=1 -> level reaches 8, 9th byte dropped, overflow[1]=1; pulse ovf_clr[1] -> 0; release inhibit -> 8 bytes emitted in order.
- Assert inhibit[0] during data bit 4 of 0xAA -> line returns high, busy 0, level stays 1; after release and GAP ticks, 0xAA is resent complete with parity 1.
- GAP=3, two bytes on ch0 -> second start bit at tick 15 after the first start; both channels loaded simultaneously transmit concurrently and independently.
- Write with wr_ch=5 (CHANNELS=2) -> no level change, no overflow; write and pop in the same cycle at level 8 -> accepted, level stays 8, overflow stays 0.
- reset_n low mid-frame -> ps2_clk/ps2_data immediately 1, levels 0, overflow 0; after release, no transmission until a new write.
